button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Conditions the raw push-button inputs before they enter the Nios II system's input PIO.
- Per bit: 2-FF synchroniser, polarity normalisation, debounce filter, press/release edge pulses, long-press detection, and sticky software-clearable event flags.
- btn_level drives the PIO input export; btn_press, btn_long and event_flags are available to an edge-capture PIO or an interrupt line.
- Sits between the board pins and the processor system in the top level.

Parameters:
- WIDTH, 2: number of buttons.
- ACTIVE_LOW, 1: 1 = raw pin reads 0 when pressed (board KEYs); 0 = active-high.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a change (20 ms at 50 MHz); must be >= 2.
- LONG_CYCLES, 50000000: cycles a debounced press must persist to raise btn_long (1 s at 50 MHz); must be >= 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_raw  in  WIDTH  unsynchronised button pins.
- event_clear  in  WIDTH  per-bit clear for event_flags; level-sensitive, sampled each edge.
- btn_level  out  WIDTH  debounced state; 1 = pressed.
- btn_press  out  WIDTH  one-cycle pulse on accepted press.
- btn_release  out  WIDTH  one-cycle pulse on accepted release.
- btn_long  out  WIDTH  one-cycle pulse when a press has persisted LONG_CYCLES.
- event_flags  out  WIDTH  sticky "press occurred" bits.

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser flops go to the released raw value (1 if ACTIVE_LOW, else 0).
  - All counters go to 0.
  - All outputs go to 0 immediately on assertion.
  - Any in-progress debounce or long-press count is discarded.
- Synchroniser: sync1 <= btn_raw, then sync2 <= sync1.
- Polarity: pressed_s = sync2 XOR ACTIVE_LOW.
- Debounce, independent per bit. Counter width is clog2(DEBOUNCE_CYCLES).
  - If pressed_s == btn_level: counter <= 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: btn_level <= pressed_s and counter <= 0.
  - Else: counter <= counter+1.
  - A single agreeing sample anywhere in the window restarts the count (glitch rejection).
- Latency: the first rising edge that samples a new stable raw value is edge 1. btn_level changes on edge DEBOUNCE_CYCLES+2.
- Pulses:
  - btn_press is asserted on the same edge btn_level goes 0->1 and deasserts on the next edge.
  - btn_release behaves the same way for 1->0.
  - The two pulses never assert together on one bit.
- Long press: per-bit hold counter, width clog2(LONG_CYCLES+1).
  - Cleared whenever btn_level = 0 or btn_press = 1.
  - Otherwise increments, saturating at LONG_CYCLES.
  - btn_long pulses for one cycle on the edge the counter goes LONG_CYCLES-1 -> LONG_CYCLES, i.e. LONG_CYCLES edges after the btn_press edge.
  - At most one btn_long per press. No btn_long if released earlier.
- Event flags, next state per bit:
  - Set if btn_press = 1.
  - Else cleared if event_clear = 1.
  - Else held.
  - Simultaneous press and clear leaves the flag set, so no event is lost.
  - An event_clear held high suppresses nothing except holding the flag at 0 between presses.
- Bits are fully independent. Simultaneous events on different bits are all reported in the same cycle.
- No combinational path from any input to any output.

Test Plan (sim parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=8, ACTIVE_LOW=1):
- Clean press: btn_raw[0] 1->0 before edge 1 and held → btn_level[0]=1 and btn_press[0]=1 at edge 6; btn_press[0]=0 at edge 7; event_flags[0]=1 from edge 6; bit 1 unchanged.
- Bounce rejection: btn_raw[0] toggles every 2 cycles for 24 cycles, then returns to 1 → btn_level, btn_press and btn_release stay 0 throughout.
- Release and long press: hold the press 20 cycles past the btn_press edge → btn_long[0] pulses once, exactly 8 edges after btn_press. Then raise btn_raw[0] → btn_release[0] pulse and btn_level[0]=0 at edge 6 after the change. Repeat with a 5-cycle hold → no btn_long.
- Flag clear race: assert event_clear[1] on the same edge btn_press[1] pulses → event_flags[1] remains 1. Assert event_clear[1] alone → event_flags[1]=0 on the next edge.
- Reset mid-operation: reset asserted while the debounce counter is at 2, with bit 0 held pressed → all outputs 0 without waiting for a clock edge. After release with the button still held → btn_press[0] at edge 6 after the first post-reset edge.
- Dual buttons: both raw bits pressed on the same edge → both btn_press bits pulse together at edge 6; event_flags = 2'b11.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end: per-bit synchroniser, debounce, press/release/long-press
// pulses and sticky press flags, all outputs registered.
module button_conditioner_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic clear_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic flag_o
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          pressed_s;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [LW-1:0] hold_q, hold_d;
    logic          long_q, long_d;
    logic          flag_q, flag_d;

    assign pressed_s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (pressed_s != level_q) begin
            if (db_cnt_q == DB_LAST) level_d  = pressed_s;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;

        // Hold count keys off next-state level/press so btn_long lands
        // exactly LONG_CYCLES edges after the btn_press edge.
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_d || press_d) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_LAST);
        end

        // A press wins over a simultaneous clear so no event is lost.
        if (press_d)      flag_d = 1'b1;
        else if (clear_i) flag_d = 1'b0;
        else              flag_d = flag_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= ACTIVE_LOW;
            sync2_q   <= ACTIVE_LOW;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= '0;
            long_q    <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            long_q    <= long_d;
            flag_q    <= flag_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign flag_o    = flag_q;
endmodule

module button_conditioner #(
    parameter int unsigned WIDTH           = 2,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    input  logic [WIDTH-1:0] event_clear,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] btn_long,
    output logic [WIDTH-1:0] event_flags
);
    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        button_conditioner_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .raw_i     (btn_raw[g]),
            .clear_i   (event_clear[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g]),
            .long_o    (btn_long[g]),
            .flag_o    (event_flags[g])
        );
    end
endmodule
